// File: rtl/imm_gen_pipe.sv
// RV immediate generator: combinational decode of I/S/B/U/J/shamt immediates
// feeding a 2-entry valid/ready output FIFO. Outputs always come from registers.
module imm_gen_pipe #(
    parameter int XLEN    = 64,
    parameter int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] immediate,
    output logic [2:0]      imm_fmt,
    output logic            illegal
);

    typedef enum logic [2:0] {
        FMT_I       = 3'd0,
        FMT_S       = 3'd1,
        FMT_B       = 3'd2,
        FMT_U       = 3'd3,
        FMT_J       = 3'd4,
        FMT_SHAMT   = 3'd5,
        FMT_ILLEGAL = 3'd7
    } fmt_t;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              is_shift;
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;

    assign opcode   = instruction[6:0];
    assign funct3   = instruction[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign imm_i    = instruction[31:20];
    assign imm_s    = {instruction[31:25], instruction[11:7]};
    assign imm_b    = {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u    = {instruction[31:12], 12'b0};
    assign imm_j    = {instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0};

    logic [XLEN-1:0] dec_imm;
    fmt_t            dec_fmt;
    logic            dec_ill;

    // Signed-to-wider size casts perform the sign extension to XLEN.
    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_ILLEGAL;
        unique case (opcode)
            7'b0010011: begin
                if (is_shift) begin
                    dec_fmt = FMT_SHAMT;
                    dec_imm = XLEN'(instruction[20 +: SHAMT_W]);
                end else begin
                    dec_fmt = FMT_I;
                    dec_imm = XLEN'(imm_i);
                end
            end
            7'b0011011: begin
                if (is_shift) begin
                    dec_fmt = FMT_SHAMT;
                    dec_imm = XLEN'(instruction[24:20]);
                end else begin
                    dec_fmt = FMT_I;
                    dec_imm = XLEN'(imm_i);
                end
            end
            7'b0000011, 7'b1100111: begin
                dec_fmt = FMT_I;
                dec_imm = XLEN'(imm_i);
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_imm = XLEN'(imm_s);
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                dec_imm = XLEN'(imm_b);
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                dec_imm = XLEN'(imm_u);
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_imm = XLEN'(imm_j);
            end
            default: begin
                dec_fmt = FMT_ILLEGAL;
                dec_imm = '0;
            end
        endcase
    end

    assign dec_ill = (dec_fmt == FMT_ILLEGAL);

    logic [XLEN-1:0] imm_q [2];
    fmt_t            fmt_q [2];
    logic            ill_q [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;
    logic            push;
    logic            pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                fmt_q[i] <= FMT_I;
                ill_q[i] <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                imm_q[wr_ptr] <= dec_imm;
                fmt_q[wr_ptr] <= dec_fmt;
                ill_q[wr_ptr] <= dec_ill;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign immediate = imm_q[rd_ptr];
    assign imm_fmt   = fmt_q[rd_ptr];
    assign illegal   = ill_q[rd_ptr];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=64 and XLEN=32 instances on shared stimulus,
// checked every cycle against a queue-based reference plus literal vectors.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] instruction;
    logic        out_ready;

    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready64), .instruction(instruction), .out_valid(out_valid64),
        .out_ready(out_ready), .immediate(imm64), .imm_fmt(fmt64), .illegal(ill64)
    );

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready32), .instruction(instruction), .out_valid(out_valid32),
        .out_ready(out_ready), .immediate(imm32), .imm_fmt(fmt32), .illegal(ill32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
    } exp_t;

    // Reference decode: fields placed by shift/OR on a 64-bit value, then
    // trimmed to xlen bits.
    function automatic exp_t model(input int xlen, input logic [31:0] i);
        exp_t        e;
        logic [63:0] sx;
        logic [6:0]  op;
        logic [2:0]  f3;
        sx = {64{i[31]}};
        op = i[6:0];
        f3 = i[14:12];
        e.fmt = 3'd7;
        e.imm = 64'd0;
        if ((op == 7'h13 || op == 7'h1B) && (f3 == 3'd1 || f3 == 3'd5)) begin
            e.fmt = 3'd5;
            e.imm = 64'(i[25:20]) & ((xlen == 64 && op == 7'h13) ? 64'd63 : 64'd31);
        end else if (op == 7'h13 || op == 7'h1B || op == 7'h03 || op == 7'h67) begin
            e.fmt = 3'd0;
            e.imm = (sx << 12) | 64'(i[31:20]);
        end else if (op == 7'h23) begin
            e.fmt = 3'd1;
            e.imm = (sx << 12) | (64'(i[31:25]) << 5) | 64'(i[11:7]);
        end else if (op == 7'h63) begin
            e.fmt = 3'd2;
            e.imm = (sx << 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5) | (64'(i[11:8]) << 1);
        end else if (op == 7'h37 || op == 7'h17) begin
            e.fmt = 3'd3;
            e.imm = (sx << 32) | 64'(i & 32'hFFFF_F000);
        end else if (op == 7'h6F) begin
            e.fmt = 3'd4;
            e.imm = (sx << 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11) | (64'(i[30:21]) << 1);
        end
        if (xlen == 32) e.imm = e.imm & 64'h0000_0000_FFFF_FFFF;
        return e;
    endfunction

    // Reference FIFO of accepted instruction words.
    logic [31:0] q [$];
    bit m_push, m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            m_push = in_valid && (q.size() < 2);
            m_pop  = (q.size() > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_push) q.push_back(instruction);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e64, e32;
        if (rst_n && mon_en) begin
            chk("mon_in_ready64", 64'(in_ready64), 64'(q.size() < 2));
            chk("mon_in_ready32", 64'(in_ready32), 64'(q.size() < 2));
            chk("mon_out_valid64", 64'(out_valid64), 64'(q.size() != 0));
            chk("mon_out_valid32", 64'(out_valid32), 64'(q.size() != 0));
            if (q.size() != 0) begin
                e64 = model(64, q[0]);
                e32 = model(32, q[0]);
                chk("mon_imm64", imm64, e64.imm);
                chk("mon_fmt64", 64'(fmt64), 64'(e64.fmt));
                chk("mon_ill64", 64'(ill64), 64'(e64.fmt == 3'd7));
                chk("mon_imm32", 64'(imm32), e32.imm);
                chk("mon_fmt32", 64'(fmt32), 64'(e32.fmt));
                chk("mon_ill32", 64'(ill32), 64'(e32.fmt == 3'd7));
            end
        end
    end

    localparam int NV = 11;
    logic [31:0] tv_inst [NV] = '{
        32'h0020_0013, 32'hFE00_0C23, 32'hFE00_08E3, 32'h8000_00B7, 32'h0010_006F,
        32'h0210_1093, 32'h4210_5093, 32'h4030_5093, 32'h0210_109B, 32'hFFF0_3083,
        32'h0000_007F
    };
    logic [63:0] tv_e64 [NV] = '{
        64'd2, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_8000_0000,
        64'd2048, 64'd33, 64'd33, 64'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0
    };
    logic [31:0] tv_e32 [NV] = '{
        32'd2, 32'hFFFF_FFF8, 32'hFFFF_FFF0, 32'h8000_0000,
        32'd2048, 32'd1, 32'd1, 32'd3, 32'd1, 32'hFFFF_FFFF, 32'd0
    };
    logic [2:0] tv_fmt [NV] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd5, 3'd5, 3'd0, 3'd7};

    function automatic logic [31:0] addi(input int k);
        return (32'(k) << 20) | 32'h13;
    endfunction

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        instruction = 32'h0;

        for (int k = 0; k < NV; k++) begin
            e = model(64, tv_inst[k]);
            chk($sformatf("model64_imm[%0d]", k), e.imm, tv_e64[k]);
            chk($sformatf("model64_fmt[%0d]", k), 64'(e.fmt), 64'(tv_fmt[k]));
            e = model(32, tv_inst[k]);
            chk($sformatf("model32_imm[%0d]", k), e.imm, 64'(tv_e32[k]));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid64), 64'd0);
        chk("reset_imm", imm64, 64'd0);
        chk("reset_fmt", 64'(fmt64), 64'd0);
        chk("reset_ill", 64'(ill64), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 64'(in_ready64), 64'd1);

        // Each format, one instruction at a time with out_ready held high.
        for (int k = 0; k < NV; k++) begin
            in_valid    = 1'b1;
            instruction = tv_inst[k];
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("fmt_valid[%0d]", k), 64'(out_valid64), 64'd1);
            chk($sformatf("fmt_imm64[%0d]", k), imm64, tv_e64[k]);
            chk($sformatf("fmt_fmt64[%0d]", k), 64'(fmt64), 64'(tv_fmt[k]));
            chk($sformatf("fmt_ill64[%0d]", k), 64'(ill64), 64'(tv_fmt[k] == 3'd7));
            chk($sformatf("fmt_imm32[%0d]", k), 64'(imm32), 64'(tv_e32[k]));
        end
        idle(2);

        // Back-pressure: third instruction must be refused while full.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = addi(1);
        @(posedge clk);
        #1 instruction = addi(2);
        @(posedge clk);
        #1 instruction = addi(3);
        @(negedge clk);
        chk("bp_in_ready_full", 64'(in_ready64), 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_head_a", imm64, 64'd1);
        @(negedge clk);
        chk("bp_head_b", imm64, 64'd2);
        @(negedge clk);
        chk("bp_drained", 64'(out_valid64), 64'd0);
        idle(1);

        // Push and pop together at count=1.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = addi(100);
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            instruction = addi(k);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("pp_head[%0d]", k), imm64, 64'(k));
            chk($sformatf("pp_in_ready[%0d]", k), 64'(in_ready64), 64'd1);
        end
        idle(3);

        // Flush while full with a pending push.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = addi(5);
        @(posedge clk);
        #1 instruction = addi(6);
        @(posedge clk);
        #1 flush = 1'b1;
        instruction = addi(7);
        out_ready   = 1'b1;
        @(negedge clk);
        chk("flush_in_ready_full", 64'(in_ready64), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_full_empty", 64'(out_valid64), 64'd0);

        // Flush at count=1 where the push would otherwise be accepted.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = addi(8);
        @(posedge clk);
        #1 flush = 1'b1;
        instruction = addi(9);
        @(negedge clk);
        chk("flush_in_ready_one", 64'(in_ready64), 64'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("flush_dropped[%0d]", k), 64'(out_valid64), 64'd0);
        end
        idle(1);

        // Asynchronous reset in mid-cycle with a nonzero entry at the head.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = 32'hFE00_0C23;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("areset_pre_valid", 64'(out_valid64), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_out_valid", 64'(out_valid64), 64'd0);
        chk("areset_imm64", imm64, 64'd0);
        chk("areset_imm32", 64'(imm32), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("areset_in_ready", 64'(in_ready64), 64'd1);
        chk("areset_empty", 64'(out_valid64), 64'd0);
        idle(2);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
